pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined ripple-carry adder/subtractor for the digital neuron datapath. The WIDTH-bit add is split into SEG-bit segments, with one register stage per segment so the carry chain length per cycle is SEG, not WIDTH. It carries a valid/ready handshake with backpressure, an add/subtract mode, carry-out and signed-overflow flags, and optional saturation. It replaces fixed-width hand-chained full-adder macros in membrane-potential and weight-sum paths.

## Interface
- WIDTH, 10, operand/result width in bits; must be a multiple of SEG.
- SEG, 5, bits resolved per pipeline stage; STAGES = WIDTH/SEG, STAGES ≥ 1.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: A+B+cin; 1: A−B (computed as A+~B+1).
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result this cycle.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (for subtract: 1 = no borrow).
- ovf  out  1  signed (two's complement) overflow.

## Operation
- Global pipeline enable: en = !out_valid | out_ready. in_ready = en. A beat is accepted when in_valid & in_ready.
- Stage k (0..STAGES−1) adds bits [k*SEG +: SEG] of A and B_eff (B_eff = sub ? ~b : b) with the carry registered by stage k−1 (stage 0 uses sub ? 1 : cin). It registers the segment sum, the segment carry-out, and a valid bit.
- Operand bits above the current segment travel through skew registers. Already-resolved lower sum bits travel alongside them, so the final stage holds a coherent WIDTH-bit result.
- ovf = carry into MSB XOR carry out of MSB. It is computed in the final stage and registered with sum.
- When en=0, every stage register, including valid bits, holds. Bubbles are not compressed.
- Reset (rst_n=0 at an edge): all valid bits 0, and sum, cout, ovf become 0. In-flight beats are discarded with no partial output. in_ready is 1 in the first cycle after reset.

## Timing
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES−1. It is registered at edge t into stage 0 and leaves the last stage's registers as outputs; for STAGES=1 the outputs are valid the cycle after acceptance.
- Throughput: one beat per cycle while out_ready=1.
- out_valid, sum, cout and ovf stay stable while out_valid & !out_ready.
- A simultaneous pop and push in the same cycle is legal. The pipeline advances, and there is no gap.
- in_ready is combinational from out_valid and out_ready only. There is no combinational path from in_valid to out_*.

## Configuration
- PIPE_ADDER_SAT_EN defined: when ovf=1, sum clamps to the signed extreme, 0b0 followed by ones (max positive) if the MSBs of A and B_eff are 0, otherwise 0b1 followed by zeros (min negative). ovf still reports 1, and cout is unchanged.
- Not defined: sum wraps modulo 2^WIDTH. The clamp logic is absent.

## Structure
- Package pipe_adder_pkg holds the default WIDTH and SEG localparams, the mode typedef (ADD=0, SUB=1), and a function returning the saturation constants for a given WIDTH.
- Sub-module adder_seg is a combinational SEG-bit ripple segment (a, b, cin → s, cout, carry into its MSB), instantiated STAGES times in a generate loop. The top level owns all registers.
- Add a parameter check at elaboration: error if WIDTH % SEG != 0.

## Test plan
All scenarios use WIDTH=10, SEG=5 unless stated.
- Add wrap: a=1023, b=1, cin=0, sub=0 → two cycles later sum=0, cout=1, ovf=0.
- Subtract: a=5, b=7, sub=1 → sum=1022 (−2), cout=0, ovf=0. a=7, b=5 → sum=2, cout=1.
- Signed overflow: a=511, b=1 → ovf=1. sum=512 without PIPE_ADDER_SAT_EN, and sum=511 with it. a=512, b=1023 with SAT → sum=512, ovf=1.
- Streaming: 8 random back-to-back beats with out_ready=1 → 8 results on consecutive cycles, in order, matching the reference model.
- Backpressure: hold out_ready=0 for 3 cycles while a result is valid → outputs stable, in_ready=0, no beat lost or duplicated. After release, all beats drain in order.
- Reset mid-flight: assert rst_n=0 with 2 beats in flight → out_valid=0, sum=0 after the edge. No stale result appears after reset deasserts. Repeat with WIDTH=16, SEG=4 for latency 4.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the segmented pipelined adder/subtractor.
// Optional feature macro: PIPE_ADDER_SAT_EN (signed saturation on overflow).
package pipe_adder_pkg;

    localparam int unsigned PA_WIDTH = 10;
    localparam int unsigned PA_SEG   = 5;

    // Operation select; the encoding matches the raw sub input.
    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Signed extremes for a given width, right-aligned in 64 bits.
    typedef struct packed {
        logic [63:0] max_pos;
        logic [63:0] min_neg;
    } sat_const_t;

    // Returns the most positive and most negative two's-complement values.
    function automatic sat_const_t sat_consts(input int unsigned width);
        sat_const_t c;
        c.min_neg = 64'(1) << (width - 1);
        c.max_pos = c.min_neg - 64'(1);
        return c;
    endfunction

endpackage : pipe_adder_pkg

// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple-carry segment. Also exposes the carry into its
// MSB so the last segment can derive signed overflow.
module adder_seg #(
    parameter int unsigned SEG = 5
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           cin_i,
    output logic [SEG-1:0] s_o,
    output logic           cout_o,
    output logic           cmsb_o
);

    logic [SEG:0] carry;

    // Bit-serial ripple through the segment.
    always_comb begin
        carry    = '0;
        s_o      = '0;
        carry[0] = cin_i;
        for (int i = 0; i < int'(SEG); i++) begin
            s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = carry[SEG];
    assign cmsb_o = carry[SEG - 1];

endmodule : adder_seg

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor resolved SEG bits per stage, with a
// valid/ready handshake and backpressure. The whole pipeline advances together
// under one enable; bubbles are not squeezed out.
// Optional feature macro: PIPE_ADDER_SAT_EN clamps the result to the signed
// extreme on overflow; without it the sum wraps.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = PA_WIDTH,
    parameter int unsigned SEG   = PA_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / SEG;
    localparam int unsigned LAST   = STAGES - 1;

    // Elaboration-time parameter sanity checks.
    if ((WIDTH % SEG) != 0) begin : g_chk_mult
        $error("pipe_adder: WIDTH must be a multiple of SEG");
    end
    if (WIDTH < SEG) begin : g_chk_stages
        $error("pipe_adder: at least one stage is required");
    end
    if (WIDTH > 64) begin : g_chk_max
        $error("pipe_adder: WIDTH above 64 is not supported");
    end

    // Per-stage registers: skewed operands, partially resolved sum, carry, valid.
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic [WIDTH-1:0]  s_d   [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic              ovf_q;
    logic              ovf_d;

    // Stage inputs: ports for stage 0, previous stage registers otherwise.
    logic [WIDTH-1:0]  stg_a [STAGES];
    logic [WIDTH-1:0]  stg_b [STAGES];
    logic [WIDTH-1:0]  stg_s [STAGES];
    logic [STAGES-1:0] stg_c;
    logic [STAGES-1:0] stg_v;

    // Segment adder results.
    logic [SEG-1:0]    seg_s [STAGES];
    logic [STAGES-1:0] seg_co;
    logic [STAGES-1:0] seg_cm;

    logic  en;
    mode_e mode;

    assign mode      = mode_e'(sub);
    assign out_valid = v_q[LAST];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    // Stage input selection and one ripple segment per stage.
    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stg_a[k] = a;
            assign stg_b[k] = (mode == MODE_SUB) ? ~b : b;
            assign stg_s[k] = '0;
            assign stg_c[k] = (mode == MODE_SUB) ? 1'b1 : cin;
            assign stg_v[k] = in_valid;
        end else begin : g_next
            assign stg_a[k] = a_q[k-1];
            assign stg_b[k] = b_q[k-1];
            assign stg_s[k] = s_q[k-1];
            assign stg_c[k] = c_q[k-1];
            assign stg_v[k] = v_q[k-1];
        end

        adder_seg #(
            .SEG (SEG)
        ) u_seg (
            .a_i    (stg_a[k][k*SEG +: SEG]),
            .b_i    (stg_b[k][k*SEG +: SEG]),
            .cin_i  (stg_c[k]),
            .s_o    (seg_s[k]),
            .cout_o (seg_co[k]),
            .cmsb_o (seg_cm[k])
        );
    end

`ifdef PIPE_ADDER_SAT_EN
    localparam sat_const_t       SAT_C   = sat_consts(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(SAT_C.max_pos);
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(SAT_C.min_neg);
`endif

    // Next-state: splice each segment sum into the travelling result.
    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            a_d[k] = stg_a[k];
            b_d[k] = stg_b[k];
            s_d[k] = stg_s[k];
            s_d[k][k*SEG +: SEG] = seg_s[k];
        end
        c_d   = seg_co;
        v_d   = stg_v;
        ovf_d = seg_cm[LAST] ^ seg_co[LAST];
`ifdef PIPE_ADDER_SAT_EN
        // Clamp toward the sign both operands share.
        if (ovf_d) begin
            s_d[LAST] = (!stg_a[LAST][WIDTH-1] && !stg_b[LAST][WIDTH-1]) ? SAT_MAX : SAT_MIN;
        end
`endif
    end

    // Pipeline registers: synchronous clear, hold everything while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            c_q   <= c_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum  = s_q[LAST];
    assign cout = c_q[LAST];
    assign ovf  = ovf_q;

    // Last-stage operand copies and lower MSB carries have no consumer.
    logic unused_tail;
    assign unused_tail = ^{a_q[LAST], b_q[LAST], seg_cm};

endmodule : pipe_adder

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: the driver pushes hand-computed results as
// beats are accepted, a monitor pops and compares as results are consumed.
// A second 16/4 instance covers deeper latency and reset flush.
module tb_pipe_adder;

    typedef struct {
        logic [9:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

`ifdef PIPE_ADDER_SAT_EN
    localparam logic [9:0] E_511P1   = 10'd511;
    localparam logic [9:0] E_NEGOVF  = 10'd512;
    localparam logic [9:0] E_640X2   = 10'd512;
`else
    localparam logic [9:0] E_511P1   = 10'd512;
    localparam logic [9:0] E_NEGOVF  = 10'd511;
    localparam logic [9:0] E_640X2   = 10'd256;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [9:0] a_r, b_r, sum;

    logic        rst2_n, in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2;
    logic [15:0] a2, b2, sum2;

    always #5 clk = ~clk;

    pipe_adder u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_r),
        .b         (b_r),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    pipe_adder #(.WIDTH(16), .SEG(4)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst2_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .cin       (cin2),
        .sub       (sub2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .sum       (sum2),
        .cout      (cout2),
        .ovf       (ovf2)
    );

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   last_pop = 0;
    int   stream_pops = 0;
    logic stream_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Present one beat, wait until accepted, record its expected result.
    task automatic send(input logic [9:0] ta, input logic [9:0] tb, input logic tcin,
                        input logic tsub, input logic [9:0] es, input logic ec, input logic eo);
        exp_t e;
        int   g;
        a_r = ta; b_r = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        g = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            fail_now("accept_timeout");
        end else begin
            e.sum = es; e.cout = ec; e.ovf = eo;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((sb.size() != 0 || out_valid === 1'b1) && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: pop on every transfer, verify hold behaviour under backpressure.
    initial begin
        exp_t e;
        exp_t h;
        logic hold;
        hold = 1'b0;
        h.sum = '0; h.cout = 1'b0; h.ovf = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n !== 1'b1) begin
                hold = 1'b0;
            end else begin
                if (hold) chk("hold_stable", 32'({out_valid, cout, ovf, sum}),
                              32'({1'b1, h.cout, h.ovf, h.sum}));
                if (out_valid === 1'b1 && out_ready === 1'b0) begin
                    hold = 1'b1;
                    h.sum = sum; h.cout = cout; h.ovf = ovf;
                    chk("in_ready_bp", 32'(in_ready), 32'd0);
                end else if (out_valid === 1'b1) begin
                    hold = 1'b0;
                    if (sb.size() == 0) begin
                        fail_now("unexpected_out");
                    end else begin
                        e = sb.pop_front();
                        chk("sum", 32'(sum), 32'(e.sum));
                        chk("cout", 32'(cout), 32'(e.cout));
                        chk("ovf", 32'(ovf), 32'(e.ovf));
                        if (stream_chk) begin
                            if (stream_pops > 0) chk("stream_gap", 32'(cyc), 32'(last_pop + 1));
                            stream_pops++;
                        end
                        last_pop = cyc;
                    end
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a_r = '0; b_r = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        rst2_n = 1'b0; in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; rst2_n = 1'b1;

        // Reset state.
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst16_out_valid", 32'(out_valid2), 32'd0);
        chk("rst16_in_ready", 32'(in_ready2), 32'd1);
        @(posedge clk); #1;

        // Directed vectors: a, b, cin, sub -> sum, cout, ovf.
        send(10'd1023, 10'd1,    1'b0, 1'b0, 10'd0,    1'b1, 1'b0);
        send(10'd5,    10'd7,    1'b0, 1'b1, 10'd1022, 1'b0, 1'b0);
        send(10'd7,    10'd5,    1'b0, 1'b1, 10'd2,    1'b1, 1'b0);
        send(10'd511,  10'd1,    1'b0, 1'b0, E_511P1,  1'b0, 1'b1);
        send(10'd512,  10'd1023, 1'b0, 1'b0, E_NEGOVF, 1'b1, 1'b1);
        send(10'd100,  10'd200,  1'b1, 1'b0, 10'd301,  1'b0, 1'b0);
        send(10'd300,  10'd100,  1'b1, 1'b1, 10'd200,  1'b1, 1'b0);
        send(10'd512,  10'd1,    1'b0, 1'b1, E_NEGOVF, 1'b1, 1'b1);
        wait_drain();

        // Back-to-back stream: results must come out on consecutive cycles.
        stream_chk = 1'b1; stream_pops = 0;
        send(10'd31,   10'd1,    1'b0, 1'b0, 10'd32,   1'b0, 1'b0);
        send(10'd992,  10'd32,   1'b0, 1'b0, 10'd0,    1'b1, 1'b0);
        send(10'd123,  10'd256,  1'b1, 1'b0, 10'd380,  1'b0, 1'b0);
        send(10'd0,    10'd1,    1'b0, 1'b1, 10'd1023, 1'b0, 1'b0);
        send(10'd1000, 10'd1000, 1'b0, 1'b1, 10'd0,    1'b1, 1'b0);
        send(10'd640,  10'd640,  1'b0, 1'b0, E_640X2,  1'b1, 1'b1);
        send(10'd341,  10'd682,  1'b0, 1'b0, 10'd1023, 1'b0, 1'b0);
        send(10'd200,  10'd57,   1'b0, 1'b1, 10'd143,  1'b1, 1'b0);
        wait_drain();
        chk("stream_count", 32'(stream_pops), 32'd8);
        stream_chk = 1'b0;

        // Backpressure: consumer stalls while three beats are offered.
        fork
            begin
                send(10'd10,  10'd20, 1'b0, 1'b0, 10'd30,   1'b0, 1'b0);
                send(10'd1,   10'd2,  1'b0, 1'b1, 10'd1023, 1'b0, 1'b0);
                send(10'd500, 10'd11, 1'b0, 1'b0, 10'd511,  1'b0, 1'b0);
            end
            begin
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset with two beats in flight: nothing may survive.
        out_ready = 1'b0;
        send(10'd1023, 10'd1023, 1'b0, 1'b0, 10'd1022, 1'b1, 1'b0);
        send(10'd2,    10'd2,    1'b0, 1'b0, 10'd4,    1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout_ovf", 32'({cout, ovf}), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;

        // 16/4 instance: four-stage latency.
        a2 = 16'd1000; b2 = 16'd2345; cin2 = 1'b0; sub2 = 1'b0; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lat16_valid", 32'(out_valid2), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("lat16_sum", 32'(sum2), 32'd3345);
        chk("lat16_cout_ovf", 32'({cout2, ovf2}), 32'd0);
        @(posedge clk); #1;

        // 16/4 instance: reset with two beats mid-pipeline.
        a2 = 16'hFFFF; b2 = 16'h0001; in_valid2 = 1'b1;
        @(posedge clk); #1;
        a2 = 16'h1234; b2 = 16'h1111;
        @(posedge clk); #1;
        in_valid2 = 1'b0; rst2_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst16_valid", 32'(out_valid2), 32'd0);
        chk("midrst16_sum", 32'(sum2), 32'd0);
        @(posedge clk); #1;
        rst2_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst16_no_stale", 32'(out_valid2), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pipe_adder
